multi_lane_serial_reader: RTL and testbench
===========================================

// Module: multi_lane_serial_reader
// PURPOSE
//  Buffers up to BUF_SIZE bits from NUM_LANES serial lines sampled in parallel on a common read strobe.
//  Bit order (MSB-first / LSB-first) is selectable per transfer; a transfer can be aborted mid-read.
//  Sits behind the bus-protocol front ends (e.g. SPI MOSI+MISO, quad lanes) feeding the MITM interception logic.
// PARAMETERS
//  BUF_SIZE        8     max bits buffered per lane (>=2)
//  NUM_LANES       1     number of parallel serial inputs (>=1)
//  TIMEOUT_CYCLES  1024  idle sys_clk cycles before timeout (used only with READ_TIMEOUT_EN)
// PORTS
//  sys_clk     in   1                    system clock, all logic on rising edge
//  rst         in   1                    reset, asynchronous, active-high
//  start       in   1                    begin transfer (sampled in IDLE only)
//  abort       in   1                    terminate transfer in READ
//  lsb_first   in   1                    bit order, latched on start: 0=MSB-first, 1=LSB-first
//  read_sig    in   1                    sample strobe, synchronous to sys_clk, one bit per lane per cycle high
//  data_in     in   NUM_LANES            serial inputs, lane k on bit k
//  read_count  in   CTR_SIZE             bits to read per lane, CTR_SIZE=$clog2(BUF_SIZE+1)
//  data_out    out  NUM_LANES*BUF_SIZE   lane k in [k*BUF_SIZE +: BUF_SIZE]
//  done_sig    out  1                    high = idle/ready, low = transfer in progress
//  aborted_sig out  1                    last transfer ended by abort
//  timeout_sig out  1                    last transfer ended by timeout (const 0 without READ_TIMEOUT_EN)
// BEHAVIOUR
//  - rst asserted: all outputs 0, counters 0, state RESET. First clock after release: RESET->IDLE, done_sig=1.
//  - States RESET, IDLE, READ; any illegal encoding -> RESET with done_sig=0.
//  - IDLE & start: next edge enter READ, done_sig=0, aborted/timeout=0, data_out=0,
//    ctr=min(read_count,BUF_SIZE), bit index idx=0, lsb_first latched. start outside IDLE ignored.
//  - READ priority per cycle: abort > (ctr==0) > timeout > read_sig.
//    * abort: -> IDLE, done_sig=1, aborted_sig=1, partial data_out kept, no bit captured this cycle.
//    * ctr==0: -> IDLE, done_sig=1; read_sig this cycle ignored. Done rises 1 cycle after last bit captured.
//    * read_sig: every lane captures data_in[k]; ctr--, idx++.
//  - MSB-first: lane shifts left, new bit at bit 0 (first bit read ends at bit n-1).
//  - LSB-first: new bit written at bit idx (first bit read at bit 0). Both: result in low n bits, upper bits 0.
//  - read_count=0: READ entered, done_sig=1 on following edge, data_out=0.
//  - read_count>BUF_SIZE: clamped to BUF_SIZE.
//  - start and abort together in IDLE: start taken, abort ignored.
//  - rst mid-READ: immediate async clear as above; partial data lost.
// CONFIGURATION
//  READ_TIMEOUT_EN defined: cycle counter cleared on entering READ and on every read_sig;
//    reaching TIMEOUT_CYCLES in READ with ctr!=0 -> IDLE, done_sig=1, timeout_sig=1, partial data kept.
//  READ_TIMEOUT_EN undefined: no counter, timeout_sig tied 0, TIMEOUT_CYCLES unused; port list identical.
// TESTING
//  1 reset: rst pulse -> all outputs 0 while rst high; done_sig=1 one cycle after release.
//  2 MSB-first, NUM_LANES=2, count=8, lane0 bits 1,0,1,1,0,0,1,0 / lane1 0xFF -> lane0=0xB2, lane1=0xFF, done 1 cycle after 8th strobe.
//  3 LSB-first, count=5, bits 1,1,0,0,1 -> lane=0x13 (0b10011), bits [7:5]=0.
//  4 abort after 3 of 8 strobes, read_sig high same cycle -> aborted_sig=1, only 3 bits captured, done_sig=1.
//  5 read_count=0 -> done_sig low one cycle then high, data_out=0; read_count=15 with BUF_SIZE=8 -> exactly 8 bits read.
//  6 READ_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 strobes then silence -> timeout_sig=1 16 cycles after last strobe; undefined: stays in READ.

Source files
------------

// File: rtl/multi_lane_serial_reader.sv
// Multi-lane serial reader: captures up to BUF_SIZE bits per lane from NUM_LANES
// serial inputs on a shared read strobe, MSB- or LSB-first, with abort and optional timeout.
// Latency: one bit per lane per read_sig cycle; done_sig rises one cycle after the last bit.
// Backpressure: none; read_sig is the only pacing, start is ignored unless idle.
// Ports: sys_clk/rst (async, active-high); start/abort/lsb_first/read_count control a transfer;
//   read_sig + data_in[k] feed lane k; data_out[k*BUF_SIZE +: BUF_SIZE] holds lane k;
//   done_sig (idle), aborted_sig, timeout_sig report how the last transfer ended.
// Optional feature: define READ_TIMEOUT_EN to end a stalled transfer after TIMEOUT_CYCLES idle cycles.
module multi_lane_serial_reader #(
    parameter  int BUF_SIZE       = 8,
    parameter  int NUM_LANES      = 1,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CTR_SIZE       = $clog2(BUF_SIZE + 1)
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          lsb_first,
    input  logic                          read_sig,
    input  logic [NUM_LANES-1:0]          data_in,
    input  logic [CTR_SIZE-1:0]           read_count,
    output logic [NUM_LANES*BUF_SIZE-1:0] data_out,
    output logic                          done_sig,
    output logic                          aborted_sig,
    output logic                          timeout_sig
);

    localparam logic [CTR_SIZE-1:0] BUF_MAX = CTR_SIZE'(BUF_SIZE);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                          state_q;
    state_t                          state_nxt;
    logic [CTR_SIZE-1:0]             ctr_q;
    logic [CTR_SIZE-1:0]             idx_q;
    logic                            lsb_q;
    logic [NUM_LANES*BUF_SIZE-1:0]   data_q;
    logic [NUM_LANES*BUF_SIZE-1:0]   data_cap;
    logic [BUF_SIZE-1:0]             lane_tmp;
    logic                            aborted_q;
    logic                            timeout_hit;

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RESET: state_nxt = ST_IDLE;
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  if (abort || (ctr_q == '0) || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_RESET;   // illegal encoding recovers through RESET
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        done_sig    = (state_q == ST_IDLE);
        aborted_sig = aborted_q;
        data_out    = data_q;
    end

    // Next value of every lane if a bit is captured this cycle.
    // MSB-first shifts left so the first bit ends up at bit n-1; LSB-first
    // drops the bit straight into position idx.
    always_comb begin
        data_cap = data_q;
        lane_tmp = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_tmp = data_q[k*BUF_SIZE +: BUF_SIZE];
            if (lsb_q) lane_tmp = lane_tmp | (BUF_SIZE'(data_in[k]) << idx_q);
            else       lane_tmp = {lane_tmp[BUF_SIZE-2:0], data_in[k]};
            data_cap[k*BUF_SIZE +: BUF_SIZE] = lane_tmp;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ctr_q     <= '0;
            idx_q     <= '0;
            lsb_q     <= 1'b0;
            data_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ctr_q     <= (read_count > BUF_MAX) ? BUF_MAX : read_count;
                        idx_q     <= '0;
                        lsb_q     <= lsb_first;
                        data_q    <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    // abort > ctr==0 > timeout > read_sig
                    if (abort) begin
                        aborted_q <= 1'b1;
                    end else if (ctr_q == '0) begin
                        // transfer complete; a strobe in this cycle is dropped
                    end else if (timeout_hit) begin
                        // partial data kept
                    end else if (read_sig) begin
                        data_q <= data_cap;
                        ctr_q  <= ctr_q - 1'b1;
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef READ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_q;
    logic             timeout_q;

    // timer_q counts completed idle READ cycles; the cycle that would make it
    // reach TIMEOUT_CYCLES is the one that ends the transfer.
    assign timeout_hit = (ctr_q != '0) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign timeout_sig = timeout_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_READ) begin
            if (read_sig) timer_q <= '0;
            else          timer_q <= timer_q + 1'b1;
            if (!abort && timeout_hit) timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_sig = 1'b0;
`endif

endmodule

// File: tb/tb_multi_lane_serial_reader.sv
module tb_multi_lane_serial_reader;

    localparam int BS  = 8;
    localparam int NL  = 2;
    localparam int CS  = $clog2(BS + 1);

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              lsb_first = 1'b0;
    logic              read_sig = 1'b0;
    logic [NL-1:0]     data_in = '0;
    logic [CS-1:0]     read_count = '0;
    logic [NL*BS-1:0]  data_out;
    logic              done_sig;
    logic              aborted_sig;
    logic              timeout_sig;

    int n_cmp = 0;
    int n_err = 0;

    multi_lane_serial_reader #(
        .BUF_SIZE(BS), .NUM_LANES(NL), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort),
        .lsb_first(lsb_first), .read_sig(read_sig), .data_in(data_in),
        .read_count(read_count), .data_out(data_out), .done_sig(done_sig),
        .aborted_sig(aborted_sig), .timeout_sig(timeout_sig)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic begin_xfer(input logic lsb, input logic [CS-1:0] cnt);
        start = 1'b1; lsb_first = lsb; read_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input logic b0, input logic b1);
        read_sig = 1'b1; data_in = {b1, b0};
        tick();
        read_sig = 1'b0; data_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_cmp++; if ({done_sig, aborted_sig, timeout_sig} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {done_sig, aborted_sig, timeout_sig}); end
        rst = 1'b0;
        #1;
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL reset_release_done: got %b want 0", done_sig); end
        tick();
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL reset_done_after: got %b want 1", done_sig); end
    endtask

    task automatic test_msb_first();
        logic [7:0] bits0;
        bits0 = 8'b1011_0010;
        begin_xfer(1'b0, 4'd8);
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL msb_busy: got %b want 0", done_sig); end
        for (int i = 7; i >= 0; i--) strobe(bits0[i], 1'b1);
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL msb_done_early: got %b want 0", done_sig); end
        tick();
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL msb_done: got %b want 1", done_sig); end
        n_cmp++; if (data_out !== 16'hFFB2) begin n_err++; $display("FAIL msb_data: got %h want ffb2", data_out); end
    endtask

    task automatic test_lsb_first();
        logic [4:0] b0, b1;
        b0 = 5'b10011; b1 = 5'b01010;   // index i = i-th bit read
        begin_xfer(1'b1, 4'd5);
        for (int i = 0; i < 5; i++) strobe(b0[i], b1[i]);
        tick();
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL lsb_done: got %b want 1", done_sig); end
        n_cmp++; if (data_out !== 16'h0A13) begin n_err++; $display("FAIL lsb_data: got %h want 0a13", data_out); end
    endtask

    task automatic test_abort();
        begin_xfer(1'b0, 4'd8);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        abort = 1'b1; read_sig = 1'b1; data_in = 2'b11;
        tick();
        abort = 1'b0; read_sig = 1'b0; data_in = '0;
        n_cmp++; if ({done_sig, aborted_sig} !== 2'b11) begin n_err++; $display("FAIL abort_flags: got %b want 11", {done_sig, aborted_sig}); end
        n_cmp++; if (data_out !== 16'h0106) begin n_err++; $display("FAIL abort_data: got %h want 0106", data_out); end
        // start and abort together in IDLE: start wins, aborted cleared
        abort = 1'b1;
        begin_xfer(1'b0, 4'd8);
        abort = 1'b0;
        n_cmp++; if ({done_sig, aborted_sig} !== 2'b00) begin n_err++; $display("FAIL start_abort_idle: got %b want 00", {done_sig, aborted_sig}); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL start_clears_data: got %h want 0", data_out); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_count_bounds();
        logic [7:0] bits0;
        // read a non-zero value first so the clear on start is observable
        begin_xfer(1'b0, 4'd1);
        strobe(1'b1, 1'b1);
        tick();
        begin_xfer(1'b0, 4'd0);
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL cnt0_busy: got %b want 0", done_sig); end
        tick();
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL cnt0_done: got %b want 1", done_sig); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL cnt0_data: got %h want 0", data_out); end
        // clamp: 15 requested, only 8 bits taken; extra strobe on the completion cycle is dropped
        bits0 = 8'hAB;
        begin_xfer(1'b0, 4'd15);
        for (int i = 7; i >= 0; i--) strobe(bits0[i], 1'b0);
        read_sig = 1'b1; data_in = 2'b11;
        tick();
        read_sig = 1'b0; data_in = '0;
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL clamp_done: got %b want 1", done_sig); end
        n_cmp++; if (data_out !== 16'h00AB) begin n_err++; $display("FAIL clamp_data: got %h want 00ab", data_out); end
    endtask

    task automatic test_timeout();
        begin_xfer(1'b0, 4'd8);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
`ifdef READ_TIMEOUT_EN
        repeat (15) tick();
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", done_sig); end
        tick();
        n_cmp++; if ({done_sig, timeout_sig} !== 2'b11) begin n_err++; $display("FAIL tmo_flags: got %b want 11", {done_sig, timeout_sig}); end
        n_cmp++; if (data_out !== 16'h0102) begin n_err++; $display("FAIL tmo_data: got %h want 0102", data_out); end
`else
        repeat (40) tick();
        n_cmp++; if ({done_sig, timeout_sig} !== 2'b00) begin n_err++; $display("FAIL no_tmo: got %b want 00", {done_sig, timeout_sig}); end
        n_cmp++; if (data_out !== 16'h0102) begin n_err++; $display("FAIL no_tmo_data: got %h want 0102", data_out); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_read();
        begin_xfer(1'b1, 4'd8);
        strobe(1'b1, 1'b1);
        strobe(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL midrst_data: got %h want 0", data_out); end
        n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done_sig); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (done_sig !== 1'b1) begin n_err++; $display("FAIL midrst_recover: got %b want 1", done_sig); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_abort();
        test_count_bounds();
        test_timeout();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
